// File: rtl/button_step_controller_pkg.sv
// Shared front-panel types: run/halt FSM state encoding and button indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package panel_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        RST  = 2'd3
    } run_state_t;

    localparam int BTN_RUN  = 0;
    localparam int BTN_STEP = 1;
    localparam int BTN_RST  = 2;
    localparam int BTN_DISP = 3;
    localparam int NUM_BTN  = 4;

    // The processor pipeline advances only while running or for the single step cycle.
    function automatic logic clk_en_for(input run_state_t s);
        return (s == RUN) || (s == STEP);
    endfunction

endpackage

// File: rtl/button_step_controller_if.sv
// Front-panel bundle: raw buttons in, press pulses and processor controls out.
// Latency: n/a (signal grouping only).
// Backpressure: none; buttons are levels and pulses are not held for a consumer.
interface button_step_controller_if;
    import panel_pkg::*;

    logic [NUM_BTN-1:0] btn;
    logic [NUM_BTN-1:0] btn_pulse;
    logic               cpu_clk_en;
    logic               cpu_reset;
    logic [1:0]         disp_sel;
    run_state_t         run_state;

    // Board/stimulus side drives the buttons and observes the controls.
    modport master (
        output btn,
        input  btn_pulse, cpu_clk_en, cpu_reset, disp_sel, run_state
    );

    // Controller side.
    modport slave (
        input  btn,
        output btn_pulse, cpu_clk_en, cpu_reset, disp_sel, run_state
    );

endinterface

// File: rtl/button_step_controller_btn_debounce.sv
// One button: 2-flop synchronizer, stable-count debouncer, rising-edge pulse.
// Latency: raw level stable from cycle 0 gives pulse in cycle DEBOUNCE_CYCLES+3.
// Backpressure: none; glitches shorter than DEBOUNCE_CYCLES cycles are dropped.
module btn_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd5000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse
`ifdef BTN_AUTOREPEAT_EN
    ,
    output logic held
`endif
);

    logic        sync1;
    logic        sync2;
    logic        level;
    logic        level_prev;
    logic [15:0] cnt;

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync2 == level) begin
            cnt <= '0;
        end else if (cnt == DEBOUNCE_CYCLES - 16'd1) begin
            level <= ~level;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    // Registered one-cycle pulse on press only; release is silent.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_prev <= 1'b0;
            pulse      <= 1'b0;
        end else begin
            level_prev <= level;
            pulse      <= level & ~level_prev;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    // High from the pulse cycle onward while the button stays down.
    assign held = level & level_prev;
`endif

endmodule

// File: rtl/button_step_controller.sv
// Front panel: debounced buttons drive run/halt/step clock-enable, stretched CPU reset, display select.
// Latency: press pulse DEBOUNCE_CYCLES+3 cycles after a stable level; controls follow one cycle later.
// Backpressure: none. Optional auto-repeat of the step button under BTN_AUTOREPEAT_EN.
module button_step_controller
    import panel_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd5000,
    parameter logic [7:0]  RESET_HOLD      = 8'd16
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter logic [23:0] REPEAT_CYCLES   = 24'd250000
`endif
) (
    input logic                     clk,
    input logic                     reset,
    button_step_controller_if.slave bus
);

    logic [NUM_BTN-1:0] deb_pulse;
    logic [NUM_BTN-1:0] pulse;
    run_state_t         state;
    logic [7:0]         hold_cnt;
    logic               clk_en;
    logic               cpu_rst;
    logic [1:0]         disp;

`ifdef BTN_AUTOREPEAT_EN
    logic [NUM_BTN-1:0] held;
`endif

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .raw   (bus.btn[i]),
            .pulse (deb_pulse[i])
`ifdef BTN_AUTOREPEAT_EN
            ,
            .held  (held[i])
`endif
        );
    end

`ifdef BTN_AUTOREPEAT_EN
    logic [23:0] rep_cnt;
    logic        rep_pulse;

    // While step is held, emit an extra step pulse every REPEAT_CYCLES cycles after the press pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_cnt   <= '0;
            rep_pulse <= 1'b0;
        end else if (!held[BTN_STEP]) begin
            rep_cnt   <= '0;
            rep_pulse <= 1'b0;
        end else if (rep_cnt == REPEAT_CYCLES - 24'd1) begin
            rep_cnt   <= '0;
            rep_pulse <= 1'b1;
        end else begin
            rep_cnt   <= rep_cnt + 24'd1;
            rep_pulse <= 1'b0;
        end
    end

    assign pulse = deb_pulse | (NUM_BTN'(rep_pulse) << BTN_STEP);
`else
    assign pulse = deb_pulse;
`endif

    // Run/halt/step/reset FSM; clk_en and cpu_rst are registered alongside the state.
    // Priority: reset request > run/halt toggle > single step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= HALT;
            hold_cnt <= '0;
            clk_en   <= 1'b0;
            cpu_rst  <= 1'b0;
        end else if (pulse[BTN_RST]) begin
            state    <= RST;
            hold_cnt <= RESET_HOLD - 8'd1;
            clk_en   <= 1'b0;
            cpu_rst  <= 1'b1;
        end else begin
            case (state)
                HALT: begin
                    if (pulse[BTN_RUN]) begin
                        state  <= RUN;
                        clk_en <= clk_en_for(RUN);
                    end else if (pulse[BTN_STEP]) begin
                        state  <= STEP;
                        clk_en <= clk_en_for(STEP);
                    end
                end
                RUN: begin
                    if (pulse[BTN_RUN]) begin
                        state  <= HALT;
                        clk_en <= clk_en_for(HALT);
                    end
                end
                STEP: begin
                    state  <= HALT;
                    clk_en <= clk_en_for(HALT);
                end
                RST: begin
                    if (hold_cnt == 8'd0) begin
                        state   <= HALT;
                        cpu_rst <= 1'b0;
                        clk_en  <= clk_en_for(HALT);
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                default: begin
                    state   <= HALT;
                    clk_en  <= 1'b0;
                    cpu_rst <= 1'b0;
                end
            endcase
        end
    end

    // Display source select cycles 0..3 on each display press; untouched by CPU reset requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp <= 2'd0;
        end else if (pulse[BTN_DISP]) begin
            disp <= disp + 2'd1;
        end
    end

    assign bus.btn_pulse  = pulse;
    assign bus.cpu_clk_en = clk_en;
    assign bus.cpu_reset  = cpu_rst;
    assign bus.disp_sel   = disp;
    assign bus.run_state  = state;

endmodule

// File: tb/tb_button_step_controller.sv
// Directed bench for the front-panel controller with DEBOUNCE_CYCLES=4, RESET_HOLD=3.
// Latency: press pulse expected in cycle 7 after the level is applied, FSM effect in cycle 8.
// Backpressure: n/a.
module tb_button_step_controller;
    import panel_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    logic [1:0] exp_disp = 2'd0;

    always #5 clk = ~clk;

    button_step_controller_if bus();

    button_step_controller #(
        .DEBOUNCE_CYCLES(16'd4),
        .RESET_HOLD     (8'd3)
`ifdef BTN_AUTOREPEAT_EN
        ,
        .REPEAT_CYCLES  (24'd10)
`endif
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] btn;
        logic [3:0] pulse;
        logic       en;
        logic       rst;
        logic [1:0] disp;
        logic [1:0] state;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] b, input logic [3:0] p, input logic e,
                                input logic r, input logic [1:0] s);
        vec_t v;
        v.btn = b; v.pulse = p; v.en = e; v.rst = r; v.disp = 2'd0; v.state = s;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] outs();
        return {6'd0, bus.btn_pulse, bus.cpu_clk_en, bus.cpu_reset, bus.disp_sel, 2'(bus.run_state)};
    endfunction

    // Apply a press at cycle 0, expect the pulse in cycle 7 and the FSM effect in cycle 8,
    // then release and confirm the settled state.
    task automatic press_chk(input string name, input logic [3:0] m,
                             input run_state_t st8, input logic en8,
                             input run_state_t st_end, input logic en_end);
        @(negedge clk);
        bus.btn = m;
        repeat (6) @(negedge clk);
        chk({name, "_c6_pulse"}, 16'(bus.btn_pulse), 16'd0);
        @(negedge clk);
        chk({name, "_c7_pulse"}, 16'(bus.btn_pulse), 16'(m));
        if (m[BTN_DISP]) exp_disp = exp_disp + 2'd1;
        @(negedge clk);
        chk({name, "_c8"}, outs(), {6'd0, 4'd0, en8, 1'b0, exp_disp, 2'(st8)});
        bus.btn = 4'd0;
        repeat (10) @(negedge clk);
        chk({name, "_settled"}, outs(), {6'd0, 4'd0, en_end, 1'b0, exp_disp, 2'(st_end)});
    endtask

    initial begin
        int extra;
        bus.btn = 4'd0;
        reset = 1'b1;

        // Step press from HALT (cycle-by-cycle)
        for (int i = 0; i < 13; i++) begin
            logic [3:0] p;
            p = (i == 7) ? 4'b0010 : 4'b0000;
            vecs.push_back(mk((i < 10) ? 4'b0010 : 4'b0000, p, (i == 8),
                              1'b0, (i == 8) ? 2'(STEP) : 2'(HALT)));
        end
        for (int i = 0; i < 10; i++) vecs.push_back(mk(4'b0000, 4'b0000, 1'b0, 1'b0, 2'(HALT)));
        // Bounce on run button: must be rejected
        vecs.push_back(mk(4'b0001, 4'b0000, 1'b0, 1'b0, 2'(HALT)));
        vecs.push_back(mk(4'b0000, 4'b0000, 1'b0, 1'b0, 2'(HALT)));
        vecs.push_back(mk(4'b0001, 4'b0000, 1'b0, 1'b0, 2'(HALT)));
        for (int i = 0; i < 11; i++) vecs.push_back(mk(4'b0000, 4'b0000, 1'b0, 1'b0, 2'(HALT)));

        repeat (2) @(negedge clk);
        chk("reset_vals", outs(), 16'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_reset_idle", outs(), 16'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            bus.btn = vecs[i].btn;
            chk($sformatf("vec%0d", i), outs(),
                {6'd0, vecs[i].pulse, vecs[i].en, vecs[i].rst, vecs[i].disp, vecs[i].state});
        end

        // Run toggle, step ignored in RUN, toggle back to HALT, run again
        press_chk("run_on",   4'b0001, RUN,  1'b1, RUN,  1'b1);
        press_chk("step_run", 4'b0010, RUN,  1'b1, RUN,  1'b1);
        press_chk("run_off",  4'b0001, HALT, 1'b0, HALT, 1'b0);
        press_chk("run_on2",  4'b0001, RUN,  1'b1, RUN,  1'b1);

        // Reset and run pressed together in RUN: reset wins for exactly 3 cycles
        @(negedge clk);
        bus.btn = 4'b0101;
        repeat (7) @(negedge clk);
        chk("rst_c7_pulse", 16'(bus.btn_pulse), 16'b0101);
        for (int k = 8; k <= 10; k++) begin
            @(negedge clk);
            chk($sformatf("rst_c%0d", k), outs(), {6'd0, 4'd0, 1'b0, 1'b1, exp_disp, 2'(RST)});
        end
        @(negedge clk);
        chk("rst_c11", outs(), {6'd0, 4'd0, 1'b0, 1'b0, exp_disp, 2'(HALT)});
        bus.btn = 4'd0;
        repeat (10) @(negedge clk);
        chk("rst_settled", outs(), {6'd0, 4'd0, 1'b0, 1'b0, exp_disp, 2'(HALT)});

        // Display select: 1,2,3,0,1
        for (int n = 0; n < 5; n++) press_chk($sformatf("disp%0d", n), 4'b1000, HALT, 1'b0, HALT, 1'b0);
        chk("disp_after5", 16'(bus.disp_sel), 16'd1);

        // Async reset during the sixth display press's debounce
        @(negedge clk);
        bus.btn = 4'b1000;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        bus.btn = 4'd0;
        #1;
        chk("midreset_async", outs(), 16'd0);
        exp_disp = 2'd0;
        @(negedge clk);
        reset = 1'b0;
        extra = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.btn_pulse != 4'd0) extra++;
        end
        chk("midreset_no_pulse", 16'(extra), 16'd0);
        chk("midreset_disp", 16'(bus.disp_sel), 16'd0);

        // Long hold of step: one STEP per press, or repeats every 10 cycles with auto-repeat
        @(negedge clk);
        bus.btn = 4'b0010;
        for (int k = 1; k <= 60; k++) begin
            logic exp_step;
            @(negedge clk);
`ifdef BTN_AUTOREPEAT_EN
            exp_step = (k >= 8) && (k <= 48) && (((k - 8) % 10) == 0);
`else
            exp_step = (k == 8);
`endif
            chk($sformatf("hold_c%0d", k), 16'(bus.run_state == STEP), 16'(exp_step));
            if (k == 47) bus.btn = 4'd0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_step_controller.md
# button_step_controller

Front-panel input controller for the FPGA RISC-V build. It is the input-side counterpart of the LED output path. It synchronizes and debounces four push-buttons and turns presses into single-cycle events. From those events it drives a run/halt/single-step clock-enable, a stretched CPU reset, and a 2-bit display-select that picks what the LED path shows. It sits between the board pins and the divided-clock processor domain, clocked by the same divided clock.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 16'd5000: consecutive stable cycles required before a button level is accepted; minimum 2.
- RESET_HOLD, 8'd16: cycles `cpu_reset` stays high after a reset request; minimum 1.
- REPEAT_CYCLES, 24'd250000: auto-repeat period for the step button. Used only when `BTN_AUTOREPEAT_EN` is defined.

Ports:
- `clk`, input, 1: divided system clock. Single clock domain.
- `reset`, input, 1: asynchronous, active-high reset.
- `btn`, input, 4: raw asynchronous buttons, active-high.
  - [0] run/halt toggle
  - [1] single step
  - [2] CPU reset request
  - [3] display select
- `btn_pulse`, output, 4: one-cycle pulse per accepted press, per button.
- `cpu_clk_en`, output, 1: clock-enable to the processor pipeline.
- `cpu_reset`, output, 1: synchronous reset request to the processor, active-high.
- `disp_sel`, output, 2: LED source select.
- `run_state`, output, 2: FSM state. HALT=0, RUN=1, STEP=2, RST=3.

## Operation
- Per button, stage 1: a 2-flop synchronizer. Both flops reset to 0.
- Per button, stage 2: debouncer.
  - A counter increments while the synced level differs from the debounced level, and clears whenever they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level flips on the next edge and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is rejected.
- Per button, stage 3: edge detect. A 0→1 transition of the debounced level gives a registered one-cycle `btn_pulse`. A release gives no pulse.
- FSM (reset state HALT):
  - HALT: `btn_pulse[0]` goes to RUN. Otherwise `btn_pulse[1]` goes to STEP.
  - STEP: unconditionally returns to HALT after one cycle.
  - RUN: `btn_pulse[0]` goes to HALT. `btn_pulse[1]` is ignored.
  - Any state: `btn_pulse[2]` goes to RST and loads the hold counter with RESET_HOLD-1.
  - RST: the hold counter decrements each cycle. At 0 the FSM goes to HALT. A further reset pulse while in RST reloads the counter.
- Priority for simultaneous pulses: reset > run/halt > step.
- Outputs decoded from state:
  - `cpu_clk_en` = 1 in RUN or STEP, else 0.
  - `cpu_reset` = 1 in RST, else 0.
- `disp_sel`: 2-bit counter that increments on `btn_pulse[3]` and wraps 3→0. It is independent of the FSM and is not cleared by RST.
- Reset-value rules:
  - Asserting `reset` mid-operation returns every register to its reset value immediately. A press in progress is discarded and must be re-debounced.
  - Reset values of all outputs: `btn_pulse`=0, `cpu_clk_en`=0, `cpu_reset`=0, `disp_sel`=0, `run_state`=HALT.

## Timing
- Press latency: a raw level stable from cycle 0 produces `btn_pulse` high in cycle 2+DEBOUNCE_CYCLES+1, for exactly one cycle.
- The FSM registers its next state on the pulse cycle. Its outputs change in the following cycle, i.e. one cycle after the pulse.
- A step produces exactly one cycle of `cpu_clk_en`=1.
- A reset request produces exactly RESET_HOLD cycles of `cpu_reset`=1, with `cpu_clk_en`=0 throughout.
- Minimum interval between two accepted presses of one button: 2×DEBOUNCE_CYCLES (press debounce plus release debounce).

## Configuration
- `BTN_AUTOREPEAT_EN` defined:
  - While debounced `btn[1]` stays high, a repeat counter generates an extra `btn_pulse[1]` every REPEAT_CYCLES cycles after the initial pulse.
  - The repeat counter clears on release and on `reset`.
- `BTN_AUTOREPEAT_EN` undefined:
  - Exactly one pulse per press.
  - The repeat counter and the REPEAT_CYCLES logic are absent.

## Structure
- Shared package `panel_pkg`:
  - `run_state_t` enum (HALT, RUN, STEP, RST).
  - Button index constants: BTN_RUN=0, BTN_STEP=1, BTN_RST=2, BTN_DISP=3.
- Sub-module `btn_debounce`: one button's synchronizer, debouncer and edge detect, parameterized by DEBOUNCE_CYCLES and instantiated four times.
- The FSM, hold counter, display counter and auto-repeat logic stay in the top module.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and RESET_HOLD=3.
- Clean press of `btn[1]` from HALT at cycle 0 → `btn_pulse[1]` in cycle 7; `run_state`=STEP and `cpu_clk_en`=1 for cycle 8 only; HALT again from cycle 9.
- Bounce on `btn[0]`: 1,0,1,0 on alternate cycles, then low → no pulse, and `run_state` stays HALT.
- Press `btn[0]`, then press it again after release → RUN with `cpu_clk_en` held 1, then back to HALT. A `btn[1]` press while in RUN leaves the state unchanged.
- `btn[2]` and `btn[0]` pressed in the same cycle while in RUN → `cpu_reset`=1 for exactly 3 cycles with `cpu_clk_en`=0, then HALT; the run toggle is lost.
- Five `btn[3]` presses → `disp_sel` sequence 1,2,3,0,1. Assert `reset` during the 6th press's debounce → `disp_sel`=0 and no pulse.
- With `BTN_AUTOREPEAT_EN` and REPEAT_CYCLES=10, hold `btn[1]` for 40 cycles after the first pulse → 4 additional STEP cycles spaced 10 cycles apart.
